// File: rtl/stdcore_fifo_arbiter.sv
// stdcore_fifo_arbiter: round-robin, packet-locking N:1 ready/valid merge with registered output.
// Optional build macro STDCORE_FIFOARB_PRIO0_EN lets requester 0 pre-empt the rotation in IDLE.
module stdcore_fifo_arbiter #(
    parameter  int N    = 2,
    parameter  int DW   = 8,
    parameter  int LOCK = 1,
    localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic [N*DW-1:0] p,
    input  logic [N-1:0]    p_last,
    input  logic [N-1:0]    p_val,
    output logic [N-1:0]    p_rdy,
    output logic [DW-1:0]   c,
    output logic            c_last,
    output logic [IW-1:0]   c_id,
    output logic            c_val,
    input  logic            c_rdy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] c_q, c_d;
    logic          c_last_q, c_last_d;
    logic [IW-1:0] c_id_q, c_id_d;
    logic          c_val_q, c_val_d;
`ifdef STDCORE_FIFOARB_PRIO0_EN
    logic          ovr_q, ovr_d;
`endif

    logic          slot_free_s;
    logic          accept_s;
    logic          release_s;
    logic [N-1:0]  p_rdy_s;
    logic [IW:0]   pick_s;
    logic [DW-1:0] beat_dat_s;
    logic          beat_last_s;
    logic          beat_val_s;
    logic [IW-1:0] ptr_next_s;

    // Returns {found, index} of the first set request at or after start, wrapping N-1 -> 0.
    function automatic logic [IW:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] start);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(start) + i;
            idx = (idx >= N) ? (idx - N) : idx;
            res = req[idx] ? {1'b1, IW'(idx)} : res;
        end
        return res;
    endfunction

    // Granted requester's beat, handshake and release decode
    always_comb begin
        beat_dat_s  = p[int'(gnt_q) * DW +: DW];
        beat_last_s = p_last[gnt_q];
        beat_val_s  = p_val[gnt_q];
        slot_free_s = !c_val_q || c_rdy;
        p_rdy_s     = '0;
        if (state_q == BUSY) begin
            p_rdy_s[gnt_q] = slot_free_s;
        end else begin
            p_rdy_s = '0;
        end
        accept_s   = (state_q == BUSY) && beat_val_s && slot_free_s;
        release_s  = accept_s && (beat_last_s || (LOCK == 0));
        ptr_next_s = (gnt_q == IW'(N - 1)) ? '0 : (gnt_q + IW'(1));
        pick_s     = rr_pick(p_val, ptr_q);
    end

    // Grant FSM: search in IDLE, hold the grant in BUSY until release
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
`ifdef STDCORE_FIFOARB_PRIO0_EN
        ovr_d   = ovr_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef STDCORE_FIFOARB_PRIO0_EN
                // An override win leaves ptr alone so the 1..N-1 rotation is not disturbed.
                if (p_val[0]) begin
                    state_d = BUSY;
                    gnt_d   = '0;
                    ovr_d   = (ptr_q != '0);
                end else if (pick_s[IW]) begin
                    state_d = BUSY;
                    gnt_d   = pick_s[IW-1:0];
                    ovr_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
`else
                if (pick_s[IW]) begin
                    state_d = BUSY;
                    gnt_d   = pick_s[IW-1:0];
                end else begin
                    state_d = IDLE;
                end
`endif
            end
            BUSY: begin
                if (release_s) begin
                    state_d = IDLE;
`ifdef STDCORE_FIFOARB_PRIO0_EN
                    ptr_d   = ovr_q ? ptr_q : ptr_next_s;
                    ovr_d   = 1'b0;
`else
                    ptr_d   = ptr_next_s;
`endif
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = '0;
            end
        endcase
    end

    // Output register: load on accept, drop valid once consumed, otherwise hold
    always_comb begin
        c_d      = c_q;
        c_last_d = c_last_q;
        c_id_d   = c_id_q;
        c_val_d  = c_val_q;
        if (accept_s) begin
            c_d      = beat_dat_s;
            c_last_d = beat_last_s;
            c_id_d   = gnt_q;
            c_val_d  = 1'b1;
        end else if (c_rdy) begin
            c_val_d  = 1'b0;
        end else begin
            c_val_d  = c_val_q;
        end
    end

    // State and output flops
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            ptr_q    <= '0;
            c_q      <= '0;
            c_last_q <= 1'b0;
            c_id_q   <= '0;
            c_val_q  <= 1'b0;
`ifdef STDCORE_FIFOARB_PRIO0_EN
            ovr_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            c_q      <= c_d;
            c_last_q <= c_last_d;
            c_id_q   <= c_id_d;
            c_val_q  <= c_val_d;
`ifdef STDCORE_FIFOARB_PRIO0_EN
            ovr_q    <= ovr_d;
`endif
        end
    end

    assign p_rdy  = p_rdy_s;
    assign c      = c_q;
    assign c_last = c_last_q;
    assign c_id   = c_id_q;
    assign c_val  = c_val_q;

endmodule

// File: tb/tb_stdcore_fifo_arbiter.sv
// Directed self-checking bench for stdcore_fifo_arbiter: a 4-requester locking instance and a
// 3-requester non-locking instance share one clock; expectations follow STDCORE_FIFOARB_PRIO0_EN.
module tb_stdcore_fifo_arbiter;

`ifdef STDCORE_FIFOARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    logic clk = 1'b0;
    logic arst_n;

    logic [31:0] a_p;
    logic [3:0]  a_last, a_val, a_rdy;
    logic [7:0]  a_c;
    logic        a_c_last, a_c_val, a_c_rdy;
    logic [1:0]  a_c_id;

    logic [23:0] b_p;
    logic [2:0]  b_last, b_val, b_rdy;
    logic [7:0]  b_c;
    logic        b_c_last, b_c_val, b_c_rdy;
    logic [1:0]  b_c_id;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] a_base [4];
    int         a_beat [4];
    logic [7:0] b_base [3];
    int         b_beat [3];

    int         log_id  [$];
    logic [7:0] log_dat [$];
    logic       log_last[$];
    int         log_cyc [$];

    stdcore_fifo_arbiter #(.N(4), .DW(8), .LOCK(1)) u_lk (
        .clk(clk), .arst_n(arst_n), .p(a_p), .p_last(a_last), .p_val(a_val), .p_rdy(a_rdy),
        .c(a_c), .c_last(a_c_last), .c_id(a_c_id), .c_val(a_c_val), .c_rdy(a_c_rdy)
    );

    stdcore_fifo_arbiter #(.N(3), .DW(8), .LOCK(0)) u_nl (
        .clk(clk), .arst_n(arst_n), .p(b_p), .p_last(b_last), .p_val(b_val), .p_rdy(b_rdy),
        .c(b_c), .c_last(b_c_last), .c_id(b_c_id), .c_val(b_c_val), .c_rdy(b_c_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle on the locking instance; entered and left at a falling edge.
    task automatic a_step(input logic [3:0] val, input logic [3:0] last, input logic crdy,
                          output logic [3:0] acc, output logic [3:0] rdy_obs, output logic cval_obs);
        a_val   = val;
        a_last  = last;
        a_c_rdy = crdy;
        for (int i = 0; i < 4; i++) a_p[i*8 +: 8] = a_base[i] + 8'(a_beat[i]);
        #1;
        rdy_obs  = a_rdy;
        cval_obs = a_c_val;
        acc      = val & a_rdy;
        if (a_c_val && crdy) begin
            log_id.push_back(int'(a_c_id));
            log_dat.push_back(a_c);
            log_last.push_back(a_c_last);
            log_cyc.push_back(cyc);
        end
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) a_beat[i] = last[i] ? 0 : a_beat[i] + 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic b_step(input logic [2:0] val, input logic [2:0] last, input logic crdy);
        logic [2:0] acc;
        b_val   = val;
        b_last  = last;
        b_c_rdy = crdy;
        for (int i = 0; i < 3; i++) b_p[i*8 +: 8] = b_base[i] + 8'(b_beat[i]);
        #1;
        acc = val & b_rdy;
        if (b_c_val && crdy) begin
            log_id.push_back(int'(b_c_id));
            log_dat.push_back(b_c);
            log_last.push_back(b_c_last);
            log_cyc.push_back(cyc);
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (acc[i]) b_beat[i] = last[i] ? 0 : b_beat[i] + 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_log();
        log_id.delete();
        log_dat.delete();
        log_last.delete();
        log_cyc.delete();
    endtask

    task automatic quiet_inputs();
        a_val = '0; a_last = '0; a_p = '0; a_c_rdy = 1'b1;
        b_val = '0; b_last = '0; b_p = '0; b_c_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin a_beat[i] = 0; a_base[i] = 8'(i * 16); end
        for (int i = 0; i < 3; i++) begin b_beat[i] = 0; b_base[i] = 8'(i * 16); end
    endtask

    task automatic do_reset();
        quiet_inputs();
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        clear_log();
    endtask

    task automatic test_reset();
        logic [3:0] acc, rdy;
        logic       cv;
        quiet_inputs();
        arst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_c_val, a_c_last, a_c, a_c_id, a_rdy} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_a: got val=%b last=%b c=%h id=%0d rdy=%b, expected all zero",
                     a_c_val, a_c_last, a_c, a_c_id, a_rdy);
        end
        n_checks++;
        if ({b_c_val, b_c_last, b_c, b_c_id, b_rdy} !== 15'h0000) begin
            n_fail++;
            $display("FAIL reset_b: got val=%b last=%b c=%h id=%0d rdy=%b, expected all zero",
                     b_c_val, b_c_last, b_c, b_c_id, b_rdy);
        end
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            a_step(4'h0, 4'h0, 1'b1, acc, rdy, cv);
            n_checks++;
            if ({cv, rdy, b_c_val, b_rdy} !== 9'h000) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: got a_val=%b a_rdy=%b b_val=%b b_rdy=%b, expected zeros",
                         k, cv, rdy, b_c_val, b_rdy);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] acc, rdy, lst;
        logic       cv;
        int         exp_id, exp_gap;
        logic [7:0] exp_dat;
        do_reset();
        for (int k = 0; k < 200 && log_id.size() < 16; k++) begin
            for (int i = 0; i < 4; i++) lst[i] = (a_beat[i] == 1);
            a_step(4'hF, lst, 1'b1, acc, rdy, cv);
        end
        n_checks++;
        if (log_id.size() < 16) begin
            n_fail++;
            $display("FAIL rr_timeout: got %0d beats, expected 16", log_id.size());
        end
        for (int j = 0; j < log_id.size() && j < 16; j++) begin
            exp_id  = PRIO0 ? 0 : (j / 2) % 4;
            exp_dat = 8'(exp_id * 16 + (j % 2));
            n_checks++;
            if (log_id[j] !== exp_id || log_dat[j] !== exp_dat || log_last[j] !== 1'((j % 2) == 1)) begin
                n_fail++;
                $display("FAIL rr_beat%0d: got id=%0d c=%h last=%b, expected id=%0d c=%h last=%b",
                         j, log_id[j], log_dat[j], log_last[j], exp_id, exp_dat, 1'((j % 2) == 1));
            end
            if (j > 0) begin
                exp_gap = ((j % 2) == 1) ? 1 : 2;
                n_checks++;
                if (log_cyc[j] - log_cyc[j-1] !== exp_gap) begin
                    n_fail++;
                    $display("FAIL rr_gap%0d: got %0d cycles, expected %0d",
                             j, log_cyc[j] - log_cyc[j-1], exp_gap);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] acc, rdy;
        logic       cv, crdy, done;
        do_reset();
        a_base[1] = 8'hA0;
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            crdy = ((k % 4) == 0) || ((k % 4) == 3);
            a_step({2'b00, !done, 1'b0}, {2'b00, 1'(a_beat[1] == 3), 1'b0}, crdy, acc, rdy, cv);
            if (acc[1] && a_beat[1] == 0) done = 1'b1;
            if (cv && !crdy) begin
                n_checks++;
                if (rdy[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_stall_cycle%0d: got p_rdy[1]=%b, expected 0", k, rdy[1]);
                end
            end
        end
        n_checks++;
        if (log_id.size() !== 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d beats, expected 4", log_id.size());
        end
        for (int j = 0; j < log_id.size() && j < 4; j++) begin
            n_checks++;
            if (log_id[j] !== 1 || log_dat[j] !== 8'(8'hA0 + j) || log_last[j] !== 1'(j == 3)) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got id=%0d c=%h last=%b, expected id=1 c=%h last=%b",
                         j, log_id[j], log_dat[j], log_last[j], 8'(8'hA0 + j), 1'(j == 3));
            end
        end
    endtask

    task automatic test_lock_hold();
        logic [3:0] acc, rdy;
        logic       cv, v0, l0, v1;
        int         phase, hold;
        logic [7:0] exp_dat [3];
        int         exp_id  [3];
        do_reset();
        a_base[0] = 8'h50;
        a_base[1] = 8'h10;
        phase = 0; hold = 0; v1 = 1'b1;
        for (int k = 0; k < 40; k++) begin
            v0 = (phase == 0) || (phase == 2);
            l0 = (phase == 2);
            a_step({2'b00, v1, v0}, {2'b00, 1'b1, l0}, 1'b1, acc, rdy, cv);
            if (phase == 1) begin
                n_checks++;
                if (rdy[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lock_hold%0d: got p_rdy[1]=%b, expected 0", hold, rdy[1]);
                end
                hold++;
                if (hold == 10) phase = 2;
            end
            if (phase == 0 && acc[0]) phase = 1;
            if (phase == 2 && acc[0]) phase = 3;
            if (acc[1]) v1 = 1'b0;
        end
        exp_id  = '{0, 0, 1};
        exp_dat = '{8'h50, 8'h51, 8'h10};
        n_checks++;
        if (log_id.size() !== 3) begin
            n_fail++;
            $display("FAIL lock_count: got %0d beats, expected 3", log_id.size());
        end
        for (int j = 0; j < log_id.size() && j < 3; j++) begin
            n_checks++;
            if (log_id[j] !== exp_id[j] || log_dat[j] !== exp_dat[j]) begin
                n_fail++;
                $display("FAIL lock_beat%0d: got id=%0d c=%h, expected id=%0d c=%h",
                         j, log_id[j], log_dat[j], exp_id[j], exp_dat[j]);
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0] acc, rdy;
        logic       cv, started;
        int         exp_id [5];
        do_reset();
        started = 1'b0;
        for (int k = 0; k < 100 && log_id.size() < 5; k++) begin
            if (started) a_step(4'b0101, 4'b0101, 1'b1, acc, rdy, cv);
            else         a_step(4'b0010, 4'b0010, 1'b1, acc, rdy, cv);
            if (acc[1]) started = 1'b1;
        end
        exp_id = PRIO0 ? '{1, 0, 0, 0, 0} : '{1, 2, 0, 2, 0};
        n_checks++;
        if (log_id.size() < 5) begin
            n_fail++;
            $display("FAIL fair_timeout: got %0d beats, expected 5", log_id.size());
        end
        for (int j = 0; j < log_id.size() && j < 5; j++) begin
            n_checks++;
            if (log_id[j] !== exp_id[j] || log_dat[j] !== 8'(exp_id[j] * 16)) begin
                n_fail++;
                $display("FAIL fair_grant%0d: got id=%0d c=%h, expected id=%0d c=%h",
                         j, log_id[j], log_dat[j], exp_id[j], 8'(exp_id[j] * 16));
            end
        end
    endtask

    task automatic test_lock0();
        int         exp_id;
        logic [7:0] exp_dat;
        do_reset();
        for (int k = 0; k < 100 && log_id.size() < 6; k++) b_step(3'b111, 3'b000, 1'b1);
        n_checks++;
        if (log_id.size() < 6) begin
            n_fail++;
            $display("FAIL nl_timeout: got %0d beats, expected 6", log_id.size());
        end
        for (int j = 0; j < log_id.size() && j < 6; j++) begin
            exp_id  = PRIO0 ? 0 : j % 3;
            exp_dat = PRIO0 ? 8'(j) : 8'((j % 3) * 16 + j / 3);
            n_checks++;
            if (log_id[j] !== exp_id || log_dat[j] !== exp_dat || log_last[j] !== 1'b0) begin
                n_fail++;
                $display("FAIL nl_beat%0d: got id=%0d c=%h last=%b, expected id=%0d c=%h last=0",
                         j, log_id[j], log_dat[j], log_last[j], exp_id, exp_dat);
            end
            if (j > 0) begin
                n_checks++;
                if (log_cyc[j] - log_cyc[j-1] !== 2) begin
                    n_fail++;
                    $display("FAIL nl_gap%0d: got %0d cycles, expected 2", j, log_cyc[j] - log_cyc[j-1]);
                end
            end
        end
    endtask

    task automatic test_reset_midpacket();
        logic [3:0] acc, rdy;
        logic       cv, got;
        int         exp_id [2];
        do_reset();
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            a_step(4'b0100, 4'b0100, 1'b1, acc, rdy, cv);
            got = acc[2];
        end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            a_step(4'b1000, 4'b0000, 1'b1, acc, rdy, cv);
            got = acc[3];
        end
        a_step(4'b1000, 4'b0000, 1'b0, acc, rdy, cv);
        n_checks++;
        if (a_c_val !== 1'b1 || a_c !== 8'h30 || a_c_id !== 2'd3) begin
            n_fail++;
            $display("FAIL mid_held: got val=%b c=%h id=%0d, expected val=1 c=30 id=3", a_c_val, a_c, a_c_id);
        end
        #2;
        arst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_c_val, a_c_last, a_c, a_c_id, a_rdy} !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_async_reset: got val=%b last=%b c=%h id=%0d rdy=%b, expected all zero",
                     a_c_val, a_c_last, a_c, a_c_id, a_rdy);
        end
        quiet_inputs();
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        clear_log();
        for (int k = 0; k < 60 && log_id.size() < 2; k++) a_step(4'b1010, 4'b1010, 1'b1, acc, rdy, cv);
        exp_id = '{1, 3};
        n_checks++;
        if (log_id.size() < 2) begin
            n_fail++;
            $display("FAIL mid_timeout: got %0d beats, expected 2", log_id.size());
        end
        for (int j = 0; j < log_id.size() && j < 2; j++) begin
            n_checks++;
            if (log_id[j] !== exp_id[j]) begin
                n_fail++;
                $display("FAIL mid_order%0d: got id=%0d, expected id=%0d", j, log_id[j], exp_id[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_lock_hold();
        test_fairness();
        test_lock0();
        test_reset_midpacket();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
